rr_decode_arbiter: RTL and testbench

Round-robin arbiter that shares one decoded select resource among 8 requesters. It picks a winner index in rotating priority and registers that index plus its one-hot decode. It holds the grant until the winner releases or, optionally, a hold timeout fires. It sits in front of the 3-to-8 decoded select path and sequences ownership of the decoded lines.

---
 rtl/rr_arb_pkg.sv | 14 +
 rtl/rr_onehot_dec.sv | 14 +
 rtl/rr_decode_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_decode_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin decode arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W-1:0] RST_IDX = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_onehot_dec.sv
// Combinational 3-to-8 one-hot decode of the winner index.
module rr_onehot_dec
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [N_REQ-1:0] onehot_c_o
);

    always_comb begin
        onehot_c_o        = '0;
        onehot_c_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with registered index and one-hot grant.
// Optional forced revocation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    // Parameter legality.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 256)) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 2..256");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [N_REQ-1:0] win_onehot;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned       HOLD_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              tmo_q, tmo_d;
`endif

    // Rotating-priority search starting just after the previous owner.
    always_comb begin
        win_idx   = last_q;
        win_found = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!win_found && req[IDX_W'(last_q + IDX_W'(i))]) begin
                win_idx   = IDX_W'(last_q + IDX_W'(i));
                win_found = 1'b1;
            end
        end
    end

    rr_onehot_dec u_dec (
        .idx_i      (win_idx),
        .onehot_c_o (win_onehot)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (en && win_found) begin
                    state_d = GRANT;
                    gnt_d   = win_onehot;
                    idx_d   = win_idx;
                    vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    last_d  = idx_q;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LAST) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    tmo_d   = 1'b1;
                    last_d  = idx_q;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
                tmo_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= RST_IDX;
            vld_q   <= 1'b0;
            last_q  <= RST_IDX;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Testbench for rr_decode_arbiter: vector table plus hand sequences, scoreboard-checked.
// Build with ARB_TIMEOUT_EN defined to exercise the forced-revocation path (MAX_HOLD=4).
module tb_rr_decode_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       tmo;
    } exp_t;

    typedef struct {
        logic       en;
        logic [7:0] req;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    rr_decode_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] oh(input int k);
        logic [7:0] one;
        one = 8'h01;
        return one << k;
    endfunction

    function automatic void add(input logic e, input logic [7:0] r, input logic [7:0] g,
                                input logic [2:0] i, input logic v, input logic t);
        vec_t x;
        x.en      = e;
        x.req     = r;
        x.exp.gnt = g;
        x.exp.idx = i;
        x.exp.vld = v;
        x.exp.tmo = t;
        vecs.push_back(x);
    endfunction

    task automatic compare(input string nm);
        exp_t e;
        exp_t a;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sb_q.pop_front();
        a = {gnt, gnt_idx, gnt_vld, timeout};
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got gnt=%h idx=%0d vld=%b tmo=%b, required gnt=%h idx=%0d vld=%b tmo=%b",
                     nm, a.gnt, a.idx, a.vld, a.tmo, e.gnt, e.idx, e.vld, e.tmo);
        end
    endtask

    // Apply inputs, expect the given outputs one edge later.
    task automatic drive(input logic e, input logic [7:0] r, input logic [7:0] g,
                         input logic [2:0] i, input logic v, input logic t, input string nm);
        en  = e;
        req = r;
        sb_q.push_back({g, i, v, t});
        @(posedge clk);
        #1;
        compare(nm);
    endtask

    task automatic check_now(input logic [7:0] g, input logic [2:0] i, input logic v,
                             input logic t, input string nm);
        sb_q.push_back({g, i, v, t});
        compare(nm);
    endtask

    initial begin
        // single request, release, wrap-around, re-assert priority, enable gating
        add(1, 8'h01, 8'h01, 3'd0, 1, 0);
        add(1, 8'h01, 8'h01, 3'd0, 1, 0);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'h00, 8'h00, 3'd0, 0, 0);
        add(1, 8'h40, 8'h40, 3'd6, 1, 0);
        add(1, 8'h00, 8'h00, 3'd6, 0, 0);
        add(1, 8'h41, 8'h00, 3'd6, 0, 0);
        add(1, 8'h41, 8'h01, 3'd0, 1, 0);
        add(1, 8'h41, 8'h01, 3'd0, 1, 0);
        add(1, 8'h40, 8'h00, 3'd0, 0, 0);
        add(1, 8'h40, 8'h00, 3'd0, 0, 0);
        add(1, 8'h40, 8'h40, 3'd6, 1, 0);
        add(1, 8'h01, 8'h00, 3'd6, 0, 0);
        add(1, 8'h41, 8'h00, 3'd6, 0, 0);
        add(1, 8'h41, 8'h01, 3'd0, 1, 0);
        add(1, 8'h40, 8'h00, 3'd0, 0, 0);
        add(1, 8'h41, 8'h00, 3'd0, 0, 0);
        add(1, 8'h41, 8'h40, 3'd6, 1, 0);
        add(1, 8'h00, 8'h00, 3'd6, 0, 0);
        add(1, 8'h00, 8'h00, 3'd6, 0, 0);
        add(0, 8'h10, 8'h00, 3'd6, 0, 0);
        add(0, 8'h10, 8'h00, 3'd6, 0, 0);
        add(0, 8'h10, 8'h00, 3'd6, 0, 0);
        add(1, 8'h10, 8'h10, 3'd4, 1, 0);
        add(0, 8'h10, 8'h10, 3'd4, 1, 0);
        add(0, 8'h10, 8'h10, 3'd4, 1, 0);
        add(0, 8'h10, 8'h10, 3'd4, 1, 0);
        add(0, 8'h00, 8'h00, 3'd4, 0, 0);
        add(0, 8'h00, 8'h00, 3'd4, 0, 0);

        #12;
        check_now(8'h00, 3'd7, 0, 0, "reset_values");
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < vecs.size(); n++)
            drive(vecs[n].en, vecs[n].req, vecs[n].exp.gnt, vecs[n].exp.idx,
                  vecs[n].exp.vld, vecs[n].exp.tmo, $sformatf("vec%0d", n));

        // Reset from IDLE, then full rotation with req=FF and each owner releasing after 3 cycles
        rst = 1'b0;
        #1;
        check_now(8'h00, 3'd7, 0, 0, "reset_idle");
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            int         o;
            logic [7:0] b;
            o = k % 8;
            b = oh(o);
            for (int c = 0; c < 3; c++)
                drive(1, 8'hFF, b, 3'(o), 1, 0, $sformatf("rot%0d_grant", k));
            drive(1, 8'hFF & ~b, 8'h00, 3'(o), 0, 0, $sformatf("rot%0d_gap", k));
            drive(1, 8'hFF, 8'h00, 3'(o), 0, 0, $sformatf("rot%0d_idle", k));
        end

`ifdef ARB_TIMEOUT_EN
        // Held request is revoked after 4 cycles with a timeout pulse, then re-granted
        for (int c = 0; c < 4; c++)
            drive(1, 8'h08, 8'h08, 3'd3, 1, 0, $sformatf("tmo_hold%0d", c));
        drive(1, 8'h08, 8'h00, 3'd3, 0, 1, "tmo_pulse");
        drive(1, 8'h08, 8'h00, 3'd3, 0, 0, "tmo_idle");
        drive(1, 8'h08, 8'h08, 3'd3, 1, 0, "tmo_regrant");
        drive(1, 8'h00, 8'h00, 3'd3, 0, 0, "tmo_release");
        drive(1, 8'h00, 8'h00, 3'd3, 0, 0, "tmo_release_idle");
`else
        // Without the timeout feature a held request keeps the grant indefinitely
        for (int c = 0; c < 20; c++)
            drive(1, 8'h08, 8'h08, 3'd3, 1, 0, $sformatf("long_hold%0d", c));
        drive(1, 8'h00, 8'h00, 3'd3, 0, 0, "long_gap");
        drive(1, 8'h08, 8'h00, 3'd3, 0, 0, "long_idle");
        drive(1, 8'h08, 8'h08, 3'd3, 1, 0, "single_regrant");
        drive(1, 8'h00, 8'h00, 3'd3, 0, 0, "single_gap");
        drive(1, 8'h00, 8'h00, 3'd3, 0, 0, "single_idle");
`endif

        // Asynchronous reset mid-grant, then the search restarts at index 0
        drive(1, 8'h20, 8'h20, 3'd5, 1, 0, "pre_reset_grant");
        #1;
        rst = 1'b0;
        #1;
        check_now(8'h00, 3'd7, 0, 0, "reset_mid_grant");
        #1;
        rst = 1'b1;
        drive(1, 8'hFF, 8'h01, 3'd0, 1, 0, "post_reset_grant");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
